// File: rtl/gray_sync_decoder.sv
// Synchronizes a Gray count from a foreign clock domain, decodes it to binary and classifies each step.
// Optional illegal-step reporting (err, err_count) is built when GRAY_STEP_CHECK_EN is defined.
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             inc,
`ifdef GRAY_STEP_CHECK_EN
  output logic             dec,
  output logic             err,
  output logic [7:0]       err_count
`else
  output logic             dec
`endif
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  localparam logic [2:0]       FILL_LAST = 3'(SYNC_STAGES - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [4:0] bit_count(input logic [WIDTH-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_g_s;
  logic [WIDTH-1:0] dec_bin_s;
  logic [4:0]       dist_s;
  logic [WIDTH-1:0] prev_gray_r;
  logic [WIDTH-1:0] prev_gray_nx_s;
  logic [WIDTH-1:0] bin_nx_s;
  logic [2:0]       fill_cnt_r;
  logic [2:0]       fill_cnt_nx_s;
  state_t           state_r;
  state_t           state_nx_s;
  logic             valid_nx_s;
  logic             inc_nx_s;
  logic             dec_nx_s;
`ifdef GRAY_STEP_CHECK_EN
  logic             err_nx_s;
`endif

  assign sync_g_s  = sync_r[SYNC_STAGES-1];
  assign dec_bin_s = gray2bin(sync_g_s);
  assign dist_s    = bit_count(sync_g_s ^ prev_gray_r);

  // Plain flop chain into the clk domain; nothing sits between stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and next output values
  always_comb begin
    state_nx_s     = state_r;
    fill_cnt_nx_s  = fill_cnt_r;
    prev_gray_nx_s = prev_gray_r;
    bin_nx_s       = bin_out;
    valid_nx_s     = 1'b0;
    inc_nx_s       = 1'b0;
    dec_nx_s       = 1'b0;
`ifdef GRAY_STEP_CHECK_EN
    err_nx_s       = 1'b0;
`endif
    case (state_r)
      ST_FILL: begin
        if (fill_cnt_r == FILL_LAST) begin
          fill_cnt_nx_s = 3'd0;
          state_nx_s    = ST_LOAD;
        end else begin
          fill_cnt_nx_s = fill_cnt_r + 3'd1;
        end
      end
      ST_LOAD: begin
        // Priming takes whatever is present with no step classification
        prev_gray_nx_s = sync_g_s;
        bin_nx_s       = dec_bin_s;
        valid_nx_s     = 1'b1;
        state_nx_s     = ST_TRACK;
      end
      ST_TRACK: begin
        if (sync_g_s != prev_gray_r) begin
          prev_gray_nx_s = sync_g_s;
          bin_nx_s       = dec_bin_s;
          valid_nx_s     = 1'b1;
          if (dist_s == 5'd1) begin
            if (dec_bin_s == (bin_out + ONE)) begin
              inc_nx_s = 1'b1;
            end else if (dec_bin_s == (bin_out - ONE)) begin
              dec_nx_s = 1'b1;
            end else begin
              inc_nx_s = 1'b0;
            end
          end else begin
`ifdef GRAY_STEP_CHECK_EN
            err_nx_s = 1'b1;
`else
            valid_nx_s = 1'b1;
`endif
          end
        end else begin
          state_nx_s = ST_TRACK;
        end
      end
      default: begin
        state_nx_s    = ST_FILL;
        fill_cnt_nx_s = 3'd0;
      end
    endcase
  end

  // Registered outputs and tracking state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_r  <= 3'd0;
      prev_gray_r <= {WIDTH{1'b0}};
      bin_out     <= {WIDTH{1'b0}};
      bin_valid   <= 1'b0;
      inc         <= 1'b0;
      dec         <= 1'b0;
    end else begin
      fill_cnt_r  <= fill_cnt_nx_s;
      prev_gray_r <= prev_gray_nx_s;
      bin_out     <= bin_nx_s;
      bin_valid   <= valid_nx_s;
      inc         <= inc_nx_s;
      dec         <= dec_nx_s;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  // Illegal-step pulse and saturating count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err <= err_nx_s;
      if (err_nx_s && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end else begin
        err_count <= err_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Self-checking bench for gray_sync_decoder: vector table, directed corner sequences and
// randomized steps against a delay-line reference model.
module tb_gray_sync_decoder;

  localparam int W1 = 4;
  localparam int S1 = 2;
  localparam int M1 = 1 << W1;
  localparam int W2 = 6;
  localparam int S2 = 3;

  typedef struct {
    logic [W1-1:0] g;
    logic [W1-1:0] b;
    logic          i;
    logic          d;
    logic          e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W1-1:0] gin1 = 4'd0;
  logic [W1-1:0] bin1;
  logic          valid1, inc1, dec1;
  logic [W2-1:0] gin2 = 6'd0;
  logic [W2-1:0] bin2;
  logic          valid2, inc2, dec2;
`ifdef GRAY_STEP_CHECK_EN
  logic          err1, err2;
  logic [7:0]    ecnt1, ecnt2;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: values emerge from a delay line of depth S1, the first one primes
  int q[$];
  bit m_loaded;
  int m_prev, m_bin, m_cnt;
  bit m_valid, m_inc, m_dec, m_err;

  always #5 clk = ~clk;

  gray_sync_decoder #(.WIDTH(W1), .SYNC_STAGES(S1)) dut1 (
    .clk(clk), .rst(rst), .gray_in(gin1), .bin_out(bin1), .bin_valid(valid1),
    .inc(inc1), .dec(dec1)
`ifdef GRAY_STEP_CHECK_EN
    , .err(err1), .err_count(ecnt1)
`endif
  );

  gray_sync_decoder #(.WIDTH(W2), .SYNC_STAGES(S2)) dut2 (
    .clk(clk), .rst(rst), .gray_in(gin2), .bin_out(bin2), .bin_valid(valid2),
    .inc(inc2), .dec(dec2)
`ifdef GRAY_STEP_CHECK_EN
    , .err(err2), .err_count(ecnt2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int g2b(input int g);
    int b;
    b = 0;
    for (int s = 0; s < W1; s++) b = b ^ (g >> s);
    return b & (M1 - 1);
  endfunction

  task automatic model_edge();
    int g, nb, d;
    m_valid = 1'b0; m_inc = 1'b0; m_dec = 1'b0; m_err = 1'b0;
    if (rst) begin
      q.delete();
      m_loaded = 1'b0; m_prev = 0; m_bin = 0; m_cnt = 0;
    end else begin
      q.push_back(int'(gin1));
      if (q.size() > S1) begin
        g = q.pop_front();
        if (!m_loaded) begin
          m_loaded = 1'b1; m_prev = g; m_bin = g2b(g); m_valid = 1'b1;
        end else if (g != m_prev) begin
          nb = g2b(g);
          d  = $countones(g ^ m_prev);
          m_valid = 1'b1;
          if (d == 1 && nb == (m_bin + 1) % M1) m_inc = 1'b1;
          else if (d == 1 && nb == (m_bin + M1 - 1) % M1) m_dec = 1'b1;
          else if (d > 1) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
          m_prev = g; m_bin = nb;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_bin_out", bin1, m_bin);
    chk("model_bin_valid", valid1, m_valid);
    chk("model_inc", inc1, m_inc);
    chk("model_dec", dec1, m_dec);
`ifdef GRAY_STEP_CHECK_EN
    chk("model_err", err1, m_err);
    chk("model_err_count", ecnt1, m_cnt);
`endif
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   cur, r;

    // reset and prime with a held nonzero value
    gin1 = 4'b0110;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_bin_out", bin1, 0);
    chk("rst_bin_valid", valid1, 0);
    chk("rst_inc_dec", {inc1, dec1}, 0);
    chk("rst_dut2_bin", bin2, 0);
`ifdef GRAY_STEP_CHECK_EN
    chk("rst_err", {err1, ecnt1}, 0);
`endif
    tick(); tick();
    rst = 1'b0;
    for (int k = 1; k <= S1 + 1; k++) begin
      tick();
      if (k == S1 + 1) begin
        chk("prime_bin", bin1, 4'b0100);
        chk("prime_valid", valid1, 1);
        chk("prime_inc_dec", {inc1, dec1}, 0);
`ifdef GRAY_STEP_CHECK_EN
        chk("prime_err", err1, 0);
`endif
      end else begin
        chk("prime_quiet", valid1, 0);
      end
    end
    repeat (6) begin
      tick();
      chk("hold_quiet", valid1, 0);
    end

    // wider, deeper instance: one step lands exactly S2 edges after the first sampling edge
    gin2 = 6'b000001;
    for (int k = 1; k <= S2 + 1; k++) begin
      tick();
      if (k <= S2) begin
        chk("w6_early_bin", bin2, 0);
        chk("w6_early_inc", inc2, 0);
      end else begin
        chk("w6_bin", bin2, 1);
        chk("w6_inc", inc2, 1);
        chk("w6_valid", valid2, 1);
      end
    end

    // vector table: illegal entry, up sweep, wrap, down sweep, illegal jumps
    tbl.push_back('{4'b0000, 4'd0, 1'b0, 1'b0, 1'b1});
    for (int i = 1; i < M1; i++) begin
      v.g = 4'(i ^ (i >> 1)); v.b = 4'(i); v.i = 1'b1; v.d = 1'b0; v.e = 1'b0;
      tbl.push_back(v);
    end
    tbl.push_back('{4'b0000, 4'd0,  1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'b1000, 4'd15, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'b1001, 4'd14, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'b1011, 4'd13, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'b0001, 4'd1,  1'b0, 1'b0, 1'b1});
    tbl.push_back('{4'b0111, 4'd5,  1'b0, 1'b0, 1'b1});
    foreach (tbl[n]) begin
      gin1 = tbl[n].g;
      for (int k = 1; k <= 5; k++) begin
        tick();
        if (k == S1 + 1) begin
          chk("vec_bin", bin1, tbl[n].b);
          chk("vec_valid", valid1, 1);
          chk("vec_inc", inc1, tbl[n].i);
          chk("vec_dec", dec1, tbl[n].d);
`ifdef GRAY_STEP_CHECK_EN
          chk("vec_err", err1, tbl[n].e);
`endif
        end else begin
          chk("vec_quiet", valid1, 0);
        end
      end
    end

    // reset mid-stream, then re-prime with no step pulses
    gin1 = 4'b1101;
    repeat (5) tick();
    chk("pre_rst_bin", bin1, 9);
    gin1 = 4'b0011;
    rst  = 1'b1;
    #1;
    chk("async_rst_bin", bin1, 0);
    chk("async_rst_valid", valid1, 0);
    chk("async_rst_inc_dec", {inc1, dec1}, 0);
`ifdef GRAY_STEP_CHECK_EN
    chk("async_rst_err", {err1, ecnt1}, 0);
`endif
    tick();
    rst = 1'b0;
    repeat (S1 + 1) tick();
    chk("reprime_bin", bin1, 2);
    chk("reprime_valid", valid1, 1);
    chk("reprime_inc_dec", {inc1, dec1}, 0);
`ifdef GRAY_STEP_CHECK_EN
    chk("reprime_err", err1, 0);
`endif

    // randomized mostly-legal steps
    cur = 2;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50) cur = (cur + 1) % M1;
      else if (r < 75) cur = (cur + M1 - 1) % M1;
      else if (r >= 85) cur = int'($urandom_range(0, M1 - 1));
      gin1 = 4'(cur ^ (cur >> 1));
      repeat ($urandom_range(1, 3)) tick();
    end

    // back-to-back illegal jumps drive the counter into saturation
    for (int n = 0; n < 300; n++) begin
      gin1 = (n % 2 == 0) ? 4'b0001 : 4'b0111;
      tick();
    end
    repeat (4) tick();
    chk("jump_bin", bin1, 5);
`ifdef GRAY_STEP_CHECK_EN
    chk("err_count_sat", ecnt1, 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
